// File: rtl/vec_mul_ctrl_if.sv
// vec_mul_ctrl_if: job handshake, weight-FIFO and datapath sequencing signals for vec_mul_ctrl.
// Optional abort input present when VEC_MUL_CTRL_ABORT_EN is defined.
`default_nettype none

interface vec_mul_ctrl_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int MAX_VEC     = 8
);
  localparam int IDXW = (MAX_VEC > 1) ? $clog2(MAX_VEC) : 1;

  logic                   start;
  logic [ADDRESSSIZE-1:0] base_addr;
  logic [IDXW:0]          num_vec;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   weight_reload;
  logic [ADDRESSSIZE-1:0] sram_address;
  logic                   valid_address;
  logic [IDXW-1:0]        result_index;
  logic                   busy;
  logic                   end_;
`ifdef VEC_MUL_CTRL_ABORT_EN
  logic                   abort;

  modport master (
    input  start, base_addr, num_vec, fifo_empty, abort,
    output fifo_read_enable, weight_reload, sram_address, valid_address,
           result_index, busy, end_
  );
  modport slave (
    output start, base_addr, num_vec, fifo_empty, abort,
    input  fifo_read_enable, weight_reload, sram_address, valid_address,
           result_index, busy, end_
  );
`else
  modport master (
    input  start, base_addr, num_vec, fifo_empty,
    output fifo_read_enable, weight_reload, sram_address, valid_address,
           result_index, busy, end_
  );
  modport slave (
    output start, base_addr, num_vec, fifo_empty,
    input  fifo_read_enable, weight_reload, sram_address, valid_address,
           result_index, busy, end_
  );
`endif
endinterface

`default_nettype wire

// File: rtl/vec_mul_ctrl.sv
// vec_mul_ctrl: weight pop/reload, UB address streaming and latency-tracked result strobes. Rev 1.0
// Optional VEC_MUL_CTRL_ABORT_EN adds a job abort input.
`default_nettype none

module vec_mul_ctrl #(
  parameter int ADDRESSSIZE  = 10,
  parameter int MAX_VEC      = 8,
  parameter int PIPE_LATENCY = 9
) (
  input  wire           clk,
  input  wire           rstn,
  vec_mul_ctrl_if.master bus
);
  localparam int IDXW = (MAX_VEC > 1) ? $clog2(MAX_VEC) : 1;
  localparam int NVW  = IDXW + 1;
  localparam logic [NVW-1:0] MAX_NV = NVW'(MAX_VEC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    WPOP    = 3'd2,
    WRELOAD = 3'd3,
    STREAM  = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                  state, state_nx;
  logic [ADDRESSSIZE-1:0]  base_q;
  logic [ADDRESSSIZE-1:0]  addr_q;
  logic [NVW-1:0]          nvec_q;
  logic [NVW-1:0]          cnt;
  logic [PIPE_LATENCY-1:0] pipe_sr;
  logic [PIPE_LATENCY-1:0] pipe_sr_shl;
  logic [IDXW-1:0]         idx;
  logic                    start_ok;
  logic                    last_issue;
  logic                    issue;
  logic                    drain_done;
  logic                    abort_req;
  logic                    valid;

`ifdef VEC_MUL_CTRL_ABORT_EN
  assign abort_req = bus.abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign start_ok    = bus.start && (bus.num_vec != '0) && (bus.num_vec <= MAX_NV);
  assign last_issue  = (cnt == nvec_q - 1'b1);
  assign issue       = (state == STREAM);
  assign valid       = pipe_sr[PIPE_LATENCY-1];
  // Only the oldest entry left means the final strobe is on the output this cycle.
  assign pipe_sr_shl = pipe_sr << 1;
  assign drain_done  = (pipe_sr_shl == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx             = state;
    bus.fifo_read_enable = 1'b0;
    bus.weight_reload    = 1'b0;
    bus.busy             = 1'b1;
    bus.end_             = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (start_ok) state_nx = bus.fifo_empty ? WAIT_W : WPOP;
      end
      WAIT_W:  if (!bus.fifo_empty) state_nx = WPOP;
      WPOP: begin
        bus.fifo_read_enable = 1'b1;
        state_nx             = WRELOAD;
      end
      WRELOAD: begin
        bus.weight_reload = 1'b1;
        state_nx          = STREAM;
      end
      STREAM:  if (last_issue) state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = DONE;
      DONE: begin
        bus.end_ = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort_req) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q  <= '0;
      nvec_q  <= '0;
      addr_q  <= '0;
      cnt     <= '0;
      pipe_sr <= '0;
      idx     <= '0;
    end else begin
      if (state == IDLE && start_ok) begin
        base_q <= bus.base_addr;
        nvec_q <= bus.num_vec;
      end
      if (state == WRELOAD) begin
        addr_q <= base_q;
        cnt    <= '0;
      end else if (issue) begin
        cnt <= cnt + 1'b1;
        if (!last_issue) addr_q <= addr_q + 1'b1;
      end
      if (abort_req) begin
        pipe_sr <= '0;
      end else begin
        pipe_sr <= pipe_sr_shl | PIPE_LATENCY'(issue);
      end
      if (state == IDLE && start_ok) begin
        idx <= '0;
      end else if (valid) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.sram_address  = addr_q;
  assign bus.valid_address = valid;
  assign bus.result_index  = idx;

endmodule

`default_nettype wire

// File: tb/tb_vec_mul_ctrl.sv
// tb_vec_mul_ctrl: directed self-checking bench for vec_mul_ctrl (PIPE_LATENCY=9).
`default_nettype none

module tb_vec_mul_ctrl;
  localparam int AW = 10;
  localparam int MV = 8;
  localparam int PL = 9;

  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  logic [AW-1:0] prev_addr;

  always #5 clk = ~clk;

  vec_mul_ctrl_if #(.ADDRESSSIZE(AW), .MAX_VEC(MV)) bus ();

  vec_mul_ctrl #(.ADDRESSSIZE(AW), .MAX_VEC(MV), .PIPE_LATENCY(PL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " fre"},   32'(bus.fifo_read_enable), 32'd0);
    chk({tag, " wr"},    32'(bus.weight_reload),    32'd0);
    chk({tag, " addr"},  32'(bus.sram_address),     32'd0);
    chk({tag, " valid"}, 32'(bus.valid_address),    32'd0);
    chk({tag, " idx"},   32'(bus.result_index),     32'd0);
    chk({tag, " busy"},  32'(bus.busy),             32'd0);
    chk({tag, " end"},   32'(bus.end_),             32'd0);
  endtask

  // Full job with per-cycle expectations; wait_cyc>0 holds the FIFO empty until that cycle.
  task automatic run_job(input logic [AW-1:0] base, input int n, input int wait_cyc,
                         input int spurious_at);
    int o, fin, k;
    logic [AW-1:0] ea;
    string t;
    o   = wait_cyc;
    fin = 3 + o + n + PL;
    bus.base_addr  = base;
    bus.num_vec    = 4'(n);
    bus.fifo_empty = (wait_cyc > 0);
    bus.start      = 1'b1;
    for (int c = 1; c <= fin + 3; c++) begin
      tick();
      bus.start = (c == spurious_at);
      if (c == spurious_at) bus.base_addr = 10'h155;
      if (wait_cyc > 0 && c == wait_cyc) bus.fifo_empty = 1'b0;
      if (c < 3 + o)          ea = prev_addr;
      else if (c < 3 + o + n) ea = base + AW'(c - 3 - o);
      else                    ea = base + AW'(n - 1);
      k = c - (3 + o + PL);
      if (k < 0) k = 0;
      if (k > n) k = n;
      t = $sformatf("job@%0h c%0d", base, c);
      chk({t, " fre"},   32'(bus.fifo_read_enable), 32'(c == 1 + o));
      chk({t, " wr"},    32'(bus.weight_reload),    32'(c == 2 + o));
      chk({t, " addr"},  32'(bus.sram_address),     32'(ea));
      chk({t, " valid"}, 32'(bus.valid_address),    32'(c >= 3 + o + PL && c < 3 + o + PL + n));
      chk({t, " idx"},   32'(bus.result_index),     32'(k % MV));
      chk({t, " busy"},  32'(bus.busy),             32'(c <= fin));
      chk({t, " end"},   32'(bus.end_),             32'(c == fin));
    end
    prev_addr = base + AW'(n - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn           = 1'b0;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.num_vec    = '0;
    bus.fifo_empty = 1'b0;
`ifdef VEC_MUL_CTRL_ABORT_EN
    bus.abort      = 1'b0;
`endif
    prev_addr = '0;
    tick();
    tick();
    chk_idle_zero("reset");
    rstn = 1'b1;
    tick();

    run_job(10'h010, 8, 0, 0);
    run_job(10'h040, 2, 5, 0);
    run_job(10'h3FE, 3, 0, 4);

    // Illegal vector counts must be ignored.
    bus.num_vec = 4'd0;
    bus.start   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("nv0 busy c%0d", c), 32'(bus.busy), 32'd0);
      chk($sformatf("nv0 fre c%0d", c),  32'(bus.fifo_read_enable), 32'd0);
    end
    bus.num_vec = 4'd9;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("nv9 busy c%0d", c), 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;

    // Asynchronous reset at issue i=4.
    bus.base_addr = 10'h020;
    bus.num_vec   = 4'd8;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    chk("pre-reset addr", 32'(bus.sram_address), 32'h024);
    #2 rstn = 1'b0;
    #1 chk_idle_zero("async reset");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("in reset end c%0d", c), 32'(bus.end_), 32'd0);
    end
    rstn = 1'b1;
    prev_addr = '0;
    tick();
    chk("post reset busy", 32'(bus.busy), 32'd0);
    run_job(10'h055, 5, 0, 0);

`ifdef VEC_MUL_CTRL_ABORT_EN
    bus.base_addr = 10'h010;
    bus.num_vec   = 4'd8;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 13; c++) tick();
    chk("abort pre valid", 32'(bus.valid_address), 32'd1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort valid", 32'(bus.valid_address), 32'd0);
    chk("abort busy",  32'(bus.busy), 32'd0);
    chk("abort end",   32'(bus.end_), 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("post abort end c%0d", c),  32'(bus.end_), 32'd0);
      chk($sformatf("post abort busy c%0d", c), 32'(bus.busy), 32'd0);
    end
    prev_addr = 10'h017;
    run_job(10'h200, 4, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vec_mul_ctrl.md
Name: vec_mul_ctrl

Overview:
Sequencing controller for the 1x64 vector-multiply datapath.
- On `start` it pops one weight set from the weight FIFO and pulses `weight_reload`.
- It then streams a programmable number of consecutive Unified Buffer addresses, one per cycle.
- It tracks the fixed datapath latency so it can drive the result-SRAM write strobe (`valid_address`) and a result index.
- It signals completion with a one-cycle `end_` pulse and replaces hand-driven testbench sequencing of these pins.

Parameters:
- ADDRESSSIZE, 10, UB address width.
- MAX_VEC, 8, maximum vectors per job; result index width is clog2(MAX_VEC).
- PIPE_LATENCY, 9, cycles from issuing a UB address to the matching result being valid at the datapath output (includes SRAM read cycle); must be ≥1.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  job request, sampled in IDLE only
- base_addr  in  ADDRESSSIZE  first UB address of job, captured on accepted start
- num_vec  in  clog2(MAX_VEC)+1  vectors in job (1..MAX_VEC), captured on accepted start
- fifo_empty  in  1  weight FIFO empty flag
- fifo_read_enable  out  1  one-cycle weight FIFO pop
- weight_reload  out  1  one-cycle weight latch into array
- sram_address  out  ADDRESSSIZE  UB read address
- valid_address  out  1  result-SRAM write strobe
- result_index  out  clog2(MAX_VEC)  result-SRAM write address
- busy  out  1  high in every state except IDLE
- end_  out  1  one-cycle job-complete pulse

Behaviour:
- Reset (async, rstn=0): state=IDLE; all outputs 0; internal counters and latency shift register cleared. Reset mid-job abandons the job silently, with no `end_`.
- FSM states: IDLE, WAIT_W, WPOP, WRELOAD, STREAM, DRAIN, DONE.
- IDLE: on start=1 with 1≤num_vec≤MAX_VEC, capture base_addr and num_vec.
  - Next state is WPOP if fifo_empty=0, else WAIT_W.
  - start with num_vec=0 or num_vec>MAX_VEC is ignored (stay IDLE).
- WAIT_W: stay while fifo_empty=1; go to WPOP when it deasserts.
- WPOP (1 cycle): fifo_read_enable=1; next WRELOAD.
- WRELOAD (1 cycle): weight_reload=1; next STREAM.
- STREAM (num_vec cycles):
  - Drive sram_address=base_addr+i for i=0..num_vec-1.
  - Address arithmetic wraps modulo 2^ADDRESSSIZE.
  - Push a 1 into the latency shift register each cycle.
  - After the last issue, go to DRAIN.
- Latency shift register (PIPE_LATENCY deep): valid_address is high exactly PIPE_LATENCY cycles after each issue cycle, i.e. num_vec consecutive cycles.
- result_index is 0 on the first valid_address and increments after each valid_address cycle; it resets to 0 at job start.
- DRAIN: wait until the shift register is empty and the last valid_address has occurred; next DONE.
- DONE (1 cycle): end_=1; next IDLE.
- sram_address holds its last value outside STREAM.
- start while busy=1 is ignored; no queuing.
- fifo_empty is sampled only in IDLE and WAIT_W; pop happens only when it is 0, so the FIFO is never underflowed.
- Timing (start accepted at cycle 0, FIFO non-empty):
  - WPOP at cycle 1, WRELOAD at cycle 2.
  - Issue i at cycle 3+i; valid_address at cycle 3+i+PIPE_LATENCY.
  - end_ at cycle 3+num_vec+PIPE_LATENCY.
  - busy high from cycle 1 through the end_ cycle.

Optional Feature:
- Macro: VEC_MUL_CTRL_ABORT_EN.
- Defined: adds input port `abort` (1 bit).
  - abort=1 in any non-IDLE state forces IDLE next cycle and clears the latency shift register.
  - valid_address drops to 0 the next cycle; no end_ pulse.
  - A FIFO pop already performed is not undone.
  - abort in IDLE has no effect; abort has priority over start in the same cycle.
- Undefined: no `abort` port; jobs always run to completion or reset.

Test Plan:
- Basic job: PIPE_LATENCY=9, FIFO non-empty, start with base_addr=0x010, num_vec=8 at cycle 0 → fifo_read_enable at cycle 1; weight_reload at cycle 2; sram_address 0x010..0x017 at cycles 3..10; valid_address cycles 12..19 with result_index 0..7; end_ at cycle 20; busy cycles 1..20.
- Empty FIFO: start with fifo_empty=1, deassert at cycle 5 → WAIT_W holds with no pop; fifo_read_enable at cycle 6; weight_reload at cycle 7.
- Wrap and short job: base_addr=0x3FE, num_vec=3 → sram_address 0x3FE, 0x3FF, 0x000; exactly 3 valid_address cycles; end_ once.
- Illegal/busy start: num_vec=0 → busy stays 0, no pop. start pulsed mid-STREAM of a valid job → ignored; only one end_.
- Async reset mid-STREAM: rstn low at issue i=4 → all outputs 0 immediately; no end_; a new start after reset runs normally from result_index 0.
- (VEC_MUL_CTRL_ABORT_EN) abort at cycle 13 of the basic job → valid_address 0 from cycle 14; busy 0 from cycle 14; no end_; next job runs normally.
